// File: rtl/johnson_phase_monitor.sv
// Watches an N-stage Johnson counter: decodes its phase, checks code/step legality,
// locks after consecutive good steps, counts revolutions and flags sequence faults.
module johnson_phase_monitor #(
    parameter int N        = 4,
    parameter int CYC_W    = 8,
    parameter int LOCK_CNT = 2,
    localparam int PW      = $clog2(2 * N)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N-1:0]     q,
    input  logic             q_valid,
    input  logic             fault_clr,
    output logic [PW-1:0]    phase,
    output logic [2*N-1:0]   phase_oh,
    output logic             locked,
    output logic             fault,
    output logic             wrap,
    output logic [CYC_W-1:0] cycle_cnt,
    output logic [7:0]       err_cnt
);

    // State bits double as the locked/fault outputs so both come straight from flops.
    localparam logic [1:0] ST_UNLOCKED = 2'b00;
    localparam logic [1:0] ST_LOCKED   = 2'b01;
    localparam logic [1:0] ST_FAULT    = 2'b10;

    logic [1:0]     state;
    logic [N-1:0]   prev;
    logic           prev_valid;
    logic [3:0]     match_cnt;

    logic [N-1:0]   q_inv;
    logic           legal;
    int             ones;
    logic [PW-1:0]  dec_phase;
    logic [2*N-1:0] dec_oh;
    logic [N-1:0]   succ_prev;
    logic           is_step;
    logic           is_stall;
    logic           is_first;
    logic           is_bad;
    logic [4:0]     match_inc;

    assign locked = state[0];
    assign fault  = state[1];

    // A thermometer code from the LSB is 2^k-1; one from the MSB is its complement.
    always_comb begin
        q_inv = ~q;
        legal = (((q + N'(1)) & q) == '0) || (((q_inv + N'(1)) & q_inv) == '0);
        ones  = 0;
        for (int i = 0; i < N; i++) begin
            ones = ones + int'(q[i]);
        end
        dec_phase = q[N-1] ? PW'(2 * N - ones) : PW'(ones);
        dec_oh    = {{(2*N-1){1'b0}}, 1'b1} << dec_phase;
        succ_prev = {prev[N-2:0], ~prev[N-1]};
        is_step   = legal && prev_valid && (q == succ_prev);
        is_stall  = legal && prev_valid && (q == prev);
        is_first  = legal && !prev_valid;
        is_bad    = !legal || (prev_valid && !is_step && !is_stall);
        match_inc = {1'b0, match_cnt} + 5'd1;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= ST_UNLOCKED;
            prev       <= '0;
            prev_valid <= 1'b0;
            match_cnt  <= '0;
            phase      <= '0;
            phase_oh   <= '0;
            wrap       <= 1'b0;
            cycle_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            wrap <= 1'b0;
            if (q_valid) begin
                if (legal) begin
                    phase      <= dec_phase;
                    phase_oh   <= dec_oh;
                    prev       <= q;
                    prev_valid <= 1'b1;
                end else begin
                    phase_oh   <= '0;
                    prev_valid <= 1'b0;
                end
            end

            // Clearing a fault overrides whatever the same-cycle sample would have done.
            if (state == ST_FAULT && fault_clr) begin
                state      <= ST_UNLOCKED;
                match_cnt  <= '0;
                prev_valid <= 1'b0;
            end else if (q_valid) begin
                case (state)
                    ST_UNLOCKED: begin
                        if (is_first || is_bad) begin
                            match_cnt <= '0;
                        end else if (is_step) begin
                            if (match_inc >= 5'(LOCK_CNT)) begin
                                state     <= ST_LOCKED;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_inc[3:0];
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (is_bad) begin
                            state <= ST_FAULT;
                            if (err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
                        end else if (is_step && q == '0) begin
                            wrap      <= 1'b1;
                            cycle_cnt <= cycle_cnt + CYC_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed bench for johnson_phase_monitor (N=4) with hand-computed expectations.
module tb_johnson_phase_monitor;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] q = 4'b1010;
    logic       q_valid = 1'b1;
    logic       fault_clr = 1'b0;
    logic [2:0] phase;
    logic [7:0] phase_oh;
    logic       locked;
    logic       fault;
    logic       wrap;
    logic [7:0] cycle_cnt;
    logic [7:0] err_cnt;

    int test_cnt = 0;
    int fail_cnt = 0;
    int wrap_seen;
    int idx;

    logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                              4'b1111, 4'b1110, 4'b1100, 4'b1000};

    johnson_phase_monitor #(.N(4), .CYC_W(8), .LOCK_CNT(2)) dut (
        .clk(clk), .clr(clr), .q(q), .q_valid(q_valid), .fault_clr(fault_clr),
        .phase(phase), .phase_oh(phase_oh), .locked(locked), .fault(fault),
        .wrap(wrap), .cycle_cnt(cycle_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        test_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] qv, input logic v, input logic fc);
        @(negedge clk);
        q = qv;
        q_valid = v;
        fault_clr = fc;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " phase"}, 32'(phase), 32'd0);
        checkOutput({tag, " phase_oh"}, 32'(phase_oh), 32'd0);
        checkOutput({tag, " locked"}, 32'(locked), 32'd0);
        checkOutput({tag, " fault"}, 32'(fault), 32'd0);
        checkOutput({tag, " wrap"}, 32'(wrap), 32'd0);
        checkOutput({tag, " cycle_cnt"}, 32'(cycle_cnt), 32'd0);
        checkOutput({tag, " err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    // Walks the legal order from the current index, checking phase and wrap at each step.
    task automatic walkTo(input int target);
        while (idx != target) begin
            idx = (idx + 1) % 8;
            applyStimulus(codes[idx], 1'b1, 1'b0);
            checkOutput("walk phase", 32'(phase), 32'(idx));
            checkOutput("walk wrap", 32'(wrap), 32'(idx == 0));
            checkOutput("walk locked", 32'(locked), 32'd1);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");

        @(negedge clk);
        clr = 1'b0;
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("first phase", 32'(phase), 32'd0);
        checkOutput("first phase_oh", 32'(phase_oh), 32'h01);
        checkOutput("first locked", 32'(locked), 32'd0);
        applyStimulus(4'b0001, 1'b1, 1'b0);
        checkOutput("step1 locked", 32'(locked), 32'd0);
        applyStimulus(4'b0011, 1'b1, 1'b0);
        checkOutput("lock locked", 32'(locked), 32'd1);
        checkOutput("lock phase", 32'(phase), 32'd2);
        checkOutput("lock phase_oh", 32'(phase_oh), 32'h04);

        idx = 2;
        wrap_seen = 0;
        for (int k = 0; k < 24; k++) begin
            idx = (idx + 1) % 8;
            applyStimulus(codes[idx], 1'b1, 1'b0);
            checkOutput("rev phase", 32'(phase), 32'(idx));
            checkOutput("rev wrap", 32'(wrap), 32'(idx == 0));
            if (wrap) wrap_seen++;
        end
        checkOutput("rev wrap count", 32'(wrap_seen), 32'd3);
        checkOutput("rev cycle_cnt", 32'(cycle_cnt), 32'd3);
        checkOutput("rev err_cnt", 32'(err_cnt), 32'd0);

        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0111, 1'b1, 1'b0);
            checkOutput("stall phase", 32'(phase), 32'd3);
            checkOutput("stall locked", 32'(locked), 32'd1);
            checkOutput("stall fault", 32'(fault), 32'd0);
        end
        idx = 3;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b0101, 1'b0, 1'b0);
            checkOutput("gap phase", 32'(phase), 32'd3);
            checkOutput("gap locked", 32'(locked), 32'd1);
            checkOutput("gap fault", 32'(fault), 32'd0);
            checkOutput("gap wrap", 32'(wrap), 32'd0);
        end

        walkTo(2);
        checkOutput("pre-fault cycle_cnt", 32'(cycle_cnt), 32'd4);
        applyStimulus(4'b0101, 1'b1, 1'b0);
        checkOutput("fault fault", 32'(fault), 32'd1);
        checkOutput("fault locked", 32'(locked), 32'd0);
        checkOutput("fault err_cnt", 32'(err_cnt), 32'd1);
        checkOutput("fault phase_oh", 32'(phase_oh), 32'd0);
        checkOutput("fault phase hold", 32'(phase), 32'd2);
        applyStimulus(4'b0110, 1'b1, 1'b0);
        checkOutput("fault2 err_cnt", 32'(err_cnt), 32'd1);
        checkOutput("fault2 fault", 32'(fault), 32'd1);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("fclr fault", 32'(fault), 32'd0);
        checkOutput("fclr locked", 32'(locked), 32'd0);
        checkOutput("fclr err_cnt", 32'(err_cnt), 32'd1);
        applyStimulus(4'b0101, 1'b1, 1'b0);
        checkOutput("unlocked bad fault", 32'(fault), 32'd0);
        checkOutput("unlocked bad err_cnt", 32'(err_cnt), 32'd1);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0001, 1'b1, 1'b0);
        checkOutput("relock early", 32'(locked), 32'd0);
        applyStimulus(4'b0011, 1'b1, 1'b0);
        checkOutput("relock locked", 32'(locked), 32'd1);

        idx = 2;
        walkTo(0);
        checkOutput("pre-reset cycle_cnt", 32'(cycle_cnt), 32'd5);
        applyStimulus(4'b0101, 1'b1, 1'b0);
        checkOutput("pre-reset err_cnt", 32'(err_cnt), 32'd2);
        #3;
        clr = 1'b1;
        #1;
        checkAllZero("async reset");
        @(negedge clk);
        clr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/johnson_phase_monitor.md
Name: johnson_phase_monitor

Overview:
- Downstream consumer of the team's N-stage Johnson counter.
- Samples the counter's state bits and decodes them into a binary phase index and a one-hot phase vector.
- Checks every sample for a legal Johnson code and a legal step, locks after consecutive correct steps, and counts completed revolutions.
- Flags and counts sequence faults, so a corrupted counter (bad load, SEU) is visible to the system.

Parameters:
- N, 4: Johnson stages; 2N legal codes. N >= 2.
- CYC_W, 8: width of the revolution counter.
- LOCK_CNT, 2: consecutive correct steps needed to enter LOCKED. Range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-high reset.
- q  in  N  counter state. q[0] is the shift-in stage; q[N-1] is the last stage.
- q_valid  in  1  sample enable; q is ignored when low.
- fault_clr  in  1  single-cycle pulse; releases FAULT.
- phase  out  clog2(2N)  decoded phase index.
- phase_oh  out  2N  one-hot phase; all zero when the code is illegal.
- locked  out  1  FSM is in LOCKED.
- fault  out  1  FSM is in FAULT (sticky).
- wrap  out  1  one-cycle pulse on phase step 2N-1 -> 0 while LOCKED.
- cycle_cnt  out  CYC_W  revolutions seen while LOCKED; wraps modulo 2^CYC_W.
- err_cnt  out  8  fault events; saturates at 255.

Behaviour:
- clk is the only clock; clr is asynchronous and active-high.
- Reset (clr=1, any time, including mid-operation): phase=0, phase_oh=0, locked=0, fault=0, wrap=0, cycle_cnt=0, err_cnt=0, match count=0, prev-valid flag=0, FSM=UNLOCKED.
- Successor function: succ(x) = {x[N-2:0], ~x[N-1]}. For N=4 the legal order is 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000.
- Legal code: a thermometer code, i.e. 0..01..1 filled from the LSB, or 1..10..0 filled from the MSB.
- Phase index: p = popcount(q) when q[N-1]=0, else 2N - popcount(q).
- All outputs are registered. A sample taken at edge k is reflected at edge k; nothing appears combinationally.
- When q_valid=0: all state holds, wrap=0, no counting.
- Each valid sample is classified against prev, the last legal sample:
  - STEP: q legal, prev valid, q == succ(prev).
  - STALL: q legal, prev valid, q == prev.
  - BAD: q illegal, or q legal but neither STEP nor STALL.
  - FIRST: q legal, no prev.
- On a legal sample: phase and phase_oh update and prev <= q.
- On an illegal sample: phase holds, phase_oh <= 0, prev-valid <= 0.
- FSM UNLOCKED:
  - FIRST: match count = 0.
  - STEP: match count++. If match count reaches LOCK_CNT, go to LOCKED.
  - STALL: match count holds.
  - BAD: match count = 0. No fault, no err_cnt change.
- FSM LOCKED:
  - STEP or STALL: stay.
  - STEP from phase 2N-1 to 0: wrap=1 for one cycle and cycle_cnt++.
  - BAD: go to FAULT, err_cnt++ (saturating), locked=0, fault=1 on the same edge.
- FSM FAULT:
  - Samples still decode, but nothing is counted.
  - fault_clr=1: go to UNLOCKED, match count=0, prev-valid=0. err_cnt is retained.
  - fault_clr has no effect in any other state.
- Simultaneous fault_clr and BAD sample while in FAULT: the clear wins, and that sample is not used as prev.
- wrap and cycle_cnt never advance outside LOCKED.

Test Plan:
- Reset: hold clr=1 for 2 cycles with q=1010 -> all outputs 0. Release, feed 0000 -> phase=0, phase_oh=00000001, locked=0.
- Lock: from reset, feed 0000, 0001, 0011 with q_valid=1 each cycle -> locked rises on the edge sampling 0011; phase=2, phase_oh=00000100.
- Revolutions: continue a legal sequence for 3 full revolutions -> wrap pulses exactly 3 times, each on the 1000 -> 0000 step; cycle_cnt=3; err_cnt=0.
- Stall and gap: while LOCKED, repeat 0111 for 4 samples, then drop q_valid for 5 cycles with q=0101 -> locked stays 1, no fault, phase=3 throughout.
- Fault: while LOCKED at 0011, feed 0101 -> fault=1, locked=0, err_cnt=1, phase_oh=0. Feed 0110 -> err_cnt stays 1. Pulse fault_clr, then feed 0000, 0001, 0011 -> locked=1.
- Async reset mid-run: assert clr between clock edges with cycle_cnt=5 and err_cnt=2 -> all outputs are 0 immediately, without waiting for a clock edge.
